// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: buffer entry and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ifetch_pkg;

    localparam int IF_XLEN = 32;

    typedef struct packed {
        logic [IF_XLEN-1:0] instr;
        logic [IF_XLEN-1:0] pc;
        logic               err;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; head entry shown on o_dat.
// Latency: a push becomes visible at the head one cycle later.
// Backpressure: push ignored when full unless a pop happens the same cycle; clear beats push/pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fetch_entry_t           i_dat,
    output fetch_entry_t           o_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    // Empty buffer shows zeros so downstream never sees stale storage.
    assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers and occupancy; clear drops everything in one cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, responses buffered for decode; optional IFETCH_PERF_EN counters.
// Latency: gnt in cycle N, rvalid in N+1 -> if_valid_o in N+2; one instruction per cycle when streaming.
// Backpressure: no request is issued unless a buffer slot is reserved for its response; decode stalls via if_ready_i.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = IF_XLEN,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] MAX_PC     = 32'h00000100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pc_write_o,
    input  logic                  flush_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_err_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic                  if_err_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_stall_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic                  r_kill;
    logic                  w_kill_nxt;
    logic [DATA_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] w_addr_nxt;

    logic                  w_push;
    fetch_entry_t          w_push_dat;
    fetch_entry_t          w_head;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_outstanding;
    logic [CW:0]           w_used;
    logic [CW:0]           w_cap;
    logic                  w_space;
    logic                  w_bad;

    assign w_pop         = !w_empty && if_ready_i;
    assign w_outstanding = (r_state == WAIT) || (r_state == DISCARD);
    // A slot is free when buffered + in-flight entries stay below capacity, counting this cycle's pop.
    assign w_used        = {1'b0, w_count} + {{CW{1'b0}}, w_outstanding};
    assign w_cap         = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, w_pop};
    assign w_space       = (w_used < w_cap);
    assign w_bad         = (pc_i[1:0] != 2'b00) || (pc_i > MAX_PC);

    // State, pending-kill flag and captured request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_kill   <= 1'b0;
            r_addr_q <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_kill   <= w_kill_nxt;
            r_addr_q <= w_addr_nxt;
        end
    end

    // Next state, memory request, PC advance and buffer push.
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_addr_nxt  = r_addr_q;
        imem_req_o  = 1'b0;
        imem_addr_o = r_addr_q;
        pc_write_o  = 1'b0;
        w_push      = 1'b0;
        w_push_dat  = '{instr: imem_rdata_i, pc: r_addr_q, err: imem_err_i};

        case (r_state)
            IDLE: begin
                if (flush_i) begin
                    pc_write_o = 1'b1;
                end else if (w_space) begin
                    if (w_bad) begin
                        // Faulting address: report it without touching memory or the PC.
                        w_push     = 1'b1;
                        w_push_dat = '{instr: '0, pc: pc_i, err: 1'b1};
                    end else begin
                        imem_req_o  = 1'b1;
                        imem_addr_o = pc_i;
                        w_addr_nxt  = pc_i;
                        if (imem_gnt_i) begin
                            pc_write_o  = 1'b1;
                            w_state_nxt = WAIT;
                        end else begin
                            w_state_nxt = REQ;
                        end
                    end
                end
            end
            REQ: begin
                // Request stays up with a stable address until granted, even across a flush.
                imem_req_o  = 1'b1;
                imem_addr_o = r_addr_q;
                if (flush_i) begin
                    pc_write_o = 1'b1;
                    w_kill_nxt = 1'b1;
                end
                if (imem_gnt_i) begin
                    w_kill_nxt = 1'b0;
                    if (flush_i || r_kill) begin
                        w_state_nxt = DISCARD;
                    end else begin
                        pc_write_o  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush_i) begin
                    pc_write_o  = 1'b1;
                    // A response arriving with the flush is dropped and closes the transaction.
                    w_state_nxt = imem_rvalid_i ? IDLE : DISCARD;
                end else if (imem_rvalid_i) begin
                    w_push = 1'b1;
                    if (w_space && !w_bad) begin
                        imem_req_o  = 1'b1;
                        imem_addr_o = pc_i;
                        w_addr_nxt  = pc_i;
                        if (imem_gnt_i) begin
                            pc_write_o  = 1'b1;
                            w_state_nxt = WAIT;
                        end else begin
                            w_state_nxt = REQ;
                        end
                    end else begin
                        // Bad next PC is handled from IDLE, where the push port is free.
                        w_state_nxt = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (flush_i) begin
                    pc_write_o = 1'b1;
                end
                if (imem_rvalid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (rst) begin
            imem_req_o  = 1'b0;
            imem_addr_o = '0;
            pc_write_o  = 1'b0;
            w_push      = 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push && !flush_i && (!w_full || w_pop)),
        .i_pop   (w_pop),
        .i_clear (flush_i),
        .i_dat   (w_push_dat),
        .o_dat   (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign if_valid_o = !w_empty;
    assign if_instr_o = w_head.instr;
    assign if_pc_o    = w_head.pc;
    assign if_err_o   = w_head.err;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Saturating counters: good instructions buffered and decode stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push && !flush_i && !w_push_dat.err && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 1'b1;
            end
            if (if_valid_o && !if_ready_i && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC and memory models around the DUT, decode-side scoreboard.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: decode readiness randomised or forced per scenario.
module tb_instruction_fetch;
    localparam logic [31:0] MAX_PC = 32'h00000100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        pc_write_o;
    logic        flush_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_err_o;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_stall_o;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (2),
        .MAX_PC     (MAX_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_write_o    (pc_write_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_err_o      (if_err_o)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched_o),
        .perf_stall_o   (perf_stall_o)
`endif
    );

    int checks = 0;
    int passed = 0;

    // Scenario knobs
    int          k_gnt = 0;
    int          k_rdy = 0;
    int          k_rvmin = 1;
    int          k_rvmax = 1;
    logic        k_rst = 1'b1;
    logic [31:0] k_rst_pc = '0;
    logic        k_flush = 1'b0;
    logic [31:0] k_tgt = '0;
    logic        k_stray = 1'b0;

    // Environment state
    logic [31:0] pc = '0;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic        prev_grant = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_pcw = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_tgt = '0;

    // Scoreboard: next PC decode should see, derived from the program order
    logic [31:0] exp_pc = '0;
    int          pops = 0;
    int          pcw_cnt = 0;

    // Sampled outputs
    logic        s_req, s_pcw, s_vld, s_err;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[5:2] == 4'hA;
    endfunction

    function automatic logic bad_pc(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > MAX_PC);
    endfunction

    task automatic tick();
        logic [31:0] ei;
        logic        ee;
        @(negedge clk);
        rst = k_rst;
        if (rst) begin
            pc         = k_rst_pc;
            m_pend     = 1'b0;
            prev_grant = 1'b0;
            prev_pcw   = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_flush) pc = prev_tgt;
            else if (prev_pcw) pc = pc + 32'd4;
            if (prev_grant) begin
                m_pend = 1'b1;
                m_addr = prev_addr;
                m_cnt  = $urandom_range(k_rvmax, k_rvmin);
            end
        end
        pc_i = pc;
        imem_rvalid_i = k_stray;
        k_stray = 1'b0;
        if (m_pend) begin
            if (m_cnt == 1) imem_rvalid_i = 1'b1;
            else m_cnt = m_cnt - 1;
        end
        if (imem_rvalid_i && m_pend) begin
            imem_rdata_i = mem_word(m_addr);
            imem_err_i   = mem_err(m_addr);
        end else begin
            imem_rdata_i = $urandom;
            imem_err_i   = 1'($urandom);
        end
        imem_gnt_i = ($urandom_range(99, 0) < k_gnt);
        if_ready_i = ($urandom_range(99, 0) < k_rdy);
        flush_i    = k_flush && !rst;
        k_flush    = 1'b0;
        prev_tgt   = k_tgt;
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_pcw   = pc_write_o;
        s_vld   = if_valid_o;
        s_instr = if_instr_o;
        s_pc    = if_pc_o;
        s_err   = if_err_o;
        prev_grant = s_req && imem_gnt_i;
        prev_addr  = s_addr;
        prev_pcw   = s_pcw;
        prev_flush = flush_i;
        if (s_pcw) pcw_cnt++;
        if (!rst && s_vld && if_ready_i && !flush_i) begin
            if (bad_pc(exp_pc)) begin
                ei = '0;
                ee = 1'b1;
            end else begin
                ei = mem_word(exp_pc);
                ee = mem_err(exp_pc);
            end
            checks++;
            if ({s_pc, s_instr, s_err} !== {exp_pc, ei, ee})
                $display("FAIL pop_entry: got pc=%h instr=%h err=%b, want pc=%h instr=%h err=%b",
                         s_pc, s_instr, s_err, exp_pc, ei, ee);
            else passed++;
            pops++;
            if (!bad_pc(exp_pc)) exp_pc = exp_pc + 32'd4;
        end
        if (!rst && flush_i) exp_pc = prev_tgt;
        if (imem_rvalid_i && m_pend) m_pend = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] start);
        k_rst_pc = start;
        k_rst    = 1'b1;
        k_gnt    = 0;
        k_rdy    = 0;
        k_rvmin  = 1;
        k_rvmax  = 1;
        tick();
        tick();
        k_rst   = 1'b0;
        exp_pc  = start;
        pcw_cnt = 0;
        pops    = 0;
    endtask

    task automatic test_reset();
        k_rst_pc = 32'h0;
        k_rst = 1'b1;
        k_gnt = 100;
        k_rdy = 100;
        tick();
        checks++; if (s_req !== 1'b0) $display("FAIL rst_req: got %b want 0", s_req); else passed++;
        checks++; if (s_pcw !== 1'b0) $display("FAIL rst_pcw: got %b want 0", s_pcw); else passed++;
        checks++; if (s_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", s_vld); else passed++;
        checks++; if (s_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", s_addr); else passed++;
        checks++;
        if ({s_instr, s_pc, s_err} !== 65'h0)
            $display("FAIL rst_head: got %h/%h/%b want zeros", s_instr, s_pc, s_err);
        else passed++;
        // Start a transaction, reset in the middle, then deliver a stray response.
        do_reset(32'h0);
        k_gnt = 100;
        tick();
        k_rst = 1'b1;
        tick();
        k_rst = 1'b0;
        k_gnt = 0;
        exp_pc = 32'h0;
        k_stray = 1'b1;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL rst_req_after: got %b/%h want 1/0", s_req, s_addr); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_vld !== 1'b0) $display("FAIL stray_rvalid: got vld %b want 0", s_vld); else passed++;
        end
    endtask

    task automatic test_first_fetch();
        do_reset(32'h0);
        k_gnt = 100;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL ff_req: got %b/%h want 1/0", s_req, s_addr); else passed++;
        checks++; if (s_pcw !== 1'b1) $display("FAIL ff_pcw: got %b want 1", s_pcw); else passed++;
        k_gnt = 0;
        tick();
        checks++; if (s_vld !== 1'b0) $display("FAIL ff_early_vld: got %b want 0", s_vld); else passed++;
        tick();
        checks++; if (s_vld !== 1'b1) $display("FAIL ff_vld: got %b want 1", s_vld); else passed++;
        checks++; if (s_instr !== 32'h00500093) $display("FAIL ff_instr: got %h want 00500093", s_instr); else passed++;
        checks++; if (s_pc !== 32'h0 || s_err !== 1'b0) $display("FAIL ff_pc: got %h/%b want 0/0", s_pc, s_err); else passed++;
        checks++; if (pcw_cnt != 1) $display("FAIL ff_pcw_count: got %0d want 1", pcw_cnt); else passed++;
    endtask

    task automatic test_streaming();
        do_reset(32'h0);
        k_gnt = 100;
        k_rdy = 100;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_vld !== 1'b1 || s_pc !== 32'(i * 4))
                $display("FAIL stream_%0d: got vld=%b pc=%h want 1/%h", i, s_vld, s_pc, 32'(i * 4));
            else passed++;
        end
    endtask

    task automatic test_back_pressure();
        do_reset(32'h0);
        k_gnt = 100;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (s_req !== 1'b0) $display("FAIL bp_req_low_%0d: got %b want 0", i, s_req); else passed++;
        end
        k_rdy = 100;
        tick();
        checks++;
        if (s_vld !== 1'b1 || s_req !== 1'b1 || s_addr !== 32'h8)
            $display("FAIL bp_resume: got vld=%b req=%b addr=%h want 1/1/8", s_vld, s_req, s_addr);
        else passed++;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_flush_wait();
        do_reset(32'h0);
        k_gnt = 100;
        k_rdy = 100;
        k_rvmin = 4;
        k_rvmax = 4;
        tick();
        k_gnt = 0;
        k_flush = 1'b1;
        k_tgt = 32'h40;
        tick();
        checks++; if (s_pcw !== 1'b1) $display("FAIL fw_pcw: got %b want 1", s_pcw); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_vld !== 1'b0 || s_req !== 1'b0) $display("FAIL fw_quiet_%0d: got vld=%b req=%b want 0/0", i, s_vld, s_req); else passed++;
        end
        k_gnt = 100;
        k_rvmin = 1;
        k_rvmax = 1;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h40) $display("FAIL fw_redirect: got req=%b addr=%h want 1/40", s_req, s_addr); else passed++;
        checks++; if (s_vld !== 1'b0) $display("FAIL fw_dropped: got vld %b want 0", s_vld); else passed++;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_flush_req();
        do_reset(32'h0);
        k_rdy = 100;
        tick();
        k_flush = 1'b1;
        k_tgt = 32'h80;
        tick();
        checks++; if (s_pcw !== 1'b1) $display("FAIL fr_pcw: got %b want 1", s_pcw); else passed++;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL fr_hold: got req=%b addr=%h want 1/0", s_req, s_addr); else passed++;
        k_gnt = 100;
        tick();
        checks++; if (s_req !== 1'b1 || s_pcw !== 1'b0) $display("FAIL fr_gnt_no_pcw: got req=%b pcw=%b want 1/0", s_req, s_pcw); else passed++;
        k_gnt = 0;
        tick();
        checks++; if (s_vld !== 1'b0) $display("FAIL fr_vld_rv: got %b want 0", s_vld); else passed++;
        tick();
        checks++; if (s_vld !== 1'b0) $display("FAIL fr_dropped: got %b want 0", s_vld); else passed++;
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h80) $display("FAIL fr_redirect: got req=%b addr=%h want 1/80", s_req, s_addr); else passed++;
        k_gnt = 100;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_faults();
        do_reset(32'h102);
        k_gnt = 100;
        tick();
        checks++; if (s_req !== 1'b0 || s_pcw !== 1'b0) $display("FAIL bad_no_req: got req=%b pcw=%b want 0/0", s_req, s_pcw); else passed++;
        tick();
        checks++;
        if (s_vld !== 1'b1 || s_err !== 1'b1 || s_pc !== 32'h102 || s_instr !== 32'h0)
            $display("FAIL bad_entry: got vld=%b err=%b pc=%h instr=%h want 1/1/102/0", s_vld, s_err, s_pc, s_instr);
        else passed++;
        do_reset(32'h28);
        k_gnt = 100;
        tick();
        tick();
        tick();
        checks++;
        if (s_vld !== 1'b1 || s_err !== 1'b1 || s_pc !== 32'h28)
            $display("FAIL bus_err: got vld=%b err=%b pc=%h want 1/1/28", s_vld, s_err, s_pc);
        else passed++;
        // Run across MAX_PC: 0xFC and 0x100 fetch normally, 0x104 faults.
        do_reset(32'hFC);
        k_gnt = 100;
        k_rdy = 100;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pops < 4) $display("FAIL max_pc_pops: got %0d want >= 4", pops); else passed++;
    endtask

    task automatic test_random();
        do_reset(32'($urandom_range(32, 0)) * 32'd4);
        for (int i = 0; i < 1500; i++) begin
            k_gnt   = $urandom_range(90, 30);
            k_rdy   = $urandom_range(95, 40);
            k_rvmin = 1;
            k_rvmax = 3;
            if ($urandom_range(29, 0) == 0) begin
                k_flush = 1'b1;
                k_tgt   = 32'($urandom_range(50, 0)) * 32'd4;
                if ($urandom_range(9, 0) == 0) k_tgt = k_tgt | 32'h2;
            end
            tick();
        end
        checks++; if (pops < 100) $display("FAIL random_progress: got %0d pops want >= 100", pops); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_streaming();
        test_back_pressure();
        test_flush_wait();
        test_flush_req();
        test_faults();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
